// File: rtl/press_pattern_gen.sv
// Synthesises timed button waveforms: N short or N long presses, each followed by a
// fixed low gap, with abort support. All outputs come straight from flops.
module press_pattern_gen #(
  parameter int CLK_HZ   = 1000,
  parameter int SHORT_MS = 200,
  parameter int LONG_MS  = 1200,
  parameter int GAP_MS   = 200,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       kind,
  input  logic [3:0] count,
  input  logic       abort,
  output logic       btn,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam logic [CNT_W-1:0] SHORT_T = CNT_W'(SHORT_MS * CLK_HZ / 1000);
  localparam logic [CNT_W-1:0] LONG_T  = CNT_W'(LONG_MS * CLK_HZ / 1000);
  localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(GAP_MS * CLK_HZ / 1000);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       rem, rem_n;
  logic             kind_q, kind_n;
  logic             btn_n, busy_n, done_n, aborted_n;
  logic [CNT_W-1:0] press_t;

  assign press_t = kind_q ? LONG_T : SHORT_T;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      kind_q  <= 1'b0;
      btn     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rem     <= rem_n;
      kind_q  <= kind_n;
      btn     <= btn_n;
      busy    <= busy_n;
      done    <= done_n;
      aborted <= aborted_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rem_n     = rem;
    kind_n    = kind_q;
    btn_n     = btn;
    busy_n    = busy;
    done_n    = 1'b0;
    aborted_n = aborted;

    case (state)
      IDLE: begin
        btn_n  = 1'b0;
        busy_n = 1'b0;
        // ABORT outranks START, so a simultaneous pair leaves everything untouched
        if (start && !abort) begin
          kind_n    = kind;
          rem_n     = count;
          aborted_n = 1'b0;
          cnt_n     = '0;
          if (count != 4'd0) begin
            state_n = PRESS;
            btn_n   = 1'b1;
            busy_n  = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      PRESS: begin
        if (abort) begin
          state_n   = GAP;
          btn_n     = 1'b0;
          rem_n     = 4'd0;
          aborted_n = 1'b1;
          cnt_n     = '0;
        end else if (cnt == press_t - ONE) begin
          state_n = GAP;
          btn_n   = 1'b0;
          rem_n   = rem - 4'd1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end

      GAP: begin
        if (abort) begin
          rem_n     = 4'd0;
          aborted_n = 1'b1;
        end
        // Every press, including the last, is followed by a complete gap
        if (cnt == GAP_T - ONE) begin
          cnt_n = '0;
          if (rem != 4'd0 && !abort) begin
            state_n = PRESS;
            btn_n   = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end

      default: begin
        state_n = IDLE;
        btn_n   = 1'b0;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_press_pattern_gen.sv
// Directed bench for press_pattern_gen: expected BTN edges and DONE pulses are queued
// when commands are issued and matched against what the DUT produces.
module tb_press_pattern_gen;

  localparam int P_S = 200;
  localparam int P_L = 1200;
  localparam int G   = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       kind = 1'b0;
  logic [3:0] count = 4'd0;
  logic       abort = 1'b0;
  logic       btn, busy, done, aborted;

  press_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kind(kind), .count(count),
    .abort(abort), .btn(btn), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ev: 0 = BTN rise, 1 = BTN fall, 2 = DONE pulse
  typedef struct {
    int   ev;
    int   at;
    logic ab;
  } ev_t;
  ev_t sb[$];

  int   checks = 0;
  int   errors = 0;
  logic prev_btn = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int ev, input int at, input logic ab);
    ev_t e;
    e.ev = ev;
    e.at = at;
    e.ab = ab;
    sb.push_back(e);
  endtask

  task automatic push_seq(input int k, input logic long_kind, input int n);
    int p;
    p = long_kind ? P_L : P_S;
    for (int i = 0; i < n; i++) begin
      push(0, k + i * (p + G), 1'b0);
      push(1, k + i * (p + G) + p, 1'b0);
    end
    push(2, k + n * (p + G), 1'b0);
  endtask

  task automatic observe(input int ev, input logic ab);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", 32'(ev), 32'd99);
    end else begin
      e = sb.pop_front();
      check("event_kind", 32'(ev), 32'(e.ev));
      check("event_cycle", 32'(cyc), 32'(e.at));
      if (ev == 2) check("aborted_at_done", {31'd0, ab}, {31'd0, e.ab});
    end
  endtask

  always @(negedge clk) begin
    if (btn !== prev_btn) observe(btn ? 0 : 1, 1'b0);
    if (done === 1'b1) observe(2, aborted);
    prev_btn = btn;
  end

  // Called at a negedge: the following rising edge samples the command
  task automatic issue(input logic k, input logic [3:0] n, output int at);
    start = 1'b1;
    kind  = k;
    count = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    at = cyc;
  endtask

  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    @(negedge clk);
    while (cyc < t && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (cyc < t) check("wait_timeout", 32'(cyc), 32'(t));
  endtask

  initial begin
    int k, k2, a, d, c;

    #12;
    check("reset_btn", {31'd0, btn}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_aborted", {31'd0, aborted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single short press
    issue(1'b0, 4'd1, k);
    push_seq(k, 1'b0, 1);
    check("short_btn_after_start", {31'd0, btn}, 32'd1);
    check("short_busy_after_start", {31'd0, busy}, 32'd1);
    wait_cyc(k + 100);
    check("short_btn_mid", {31'd0, btn}, 32'd1);
    wait_cyc(k + 400);
    check("short_done", {31'd0, done}, 32'd1);
    check("short_busy_end", {31'd0, busy}, 32'd0);
    check("short_aborted", {31'd0, aborted}, 32'd0);
    @(negedge clk);
    check("short_sb_empty", 32'(sb.size()), 32'd0);

    // Single long press
    issue(1'b1, 4'd1, k);
    push_seq(k, 1'b1, 1);
    wait_cyc(k + 1400);
    check("long_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // Two long presses with a START mid-sequence that must be ignored
    issue(1'b1, 4'd2, k);
    push_seq(k, 1'b1, 2);
    wait_cyc(k + 600);
    issue(1'b0, 4'd5, a);
    wait_cyc(k + 2800);
    check("long2_done", {31'd0, done}, 32'd1);
    check("long2_aborted", {31'd0, aborted}, 32'd0);
    @(negedge clk);

    // COUNT=0: DONE right away, never busy, BTN never rises
    issue(1'b0, 4'd0, k);
    push_seq(k, 1'b0, 0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_btn", {31'd0, btn}, 32'd0);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("zero_done_one_cycle", {31'd0, done}, 32'd0);
    check("zero_busy_after", {31'd0, busy}, 32'd0);

    // Abort 500 cycles into a long press
    issue(1'b1, 4'd2, k);
    push(0, k, 1'b0);
    wait_cyc(k + 499);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    a = cyc;
    check("abort_btn_drop", {31'd0, btn}, 32'd0);
    check("abort_busy_in_gap", {31'd0, busy}, 32'd1);
    push(1, a, 1'b0);
    push(2, a + G, 1'b1);
    wait_cyc(a + G);
    check("abort_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("abort_aborted_held", {31'd0, aborted}, 32'd1);

    // Abort during a gap, then a START on the returning edge (ignored)
    issue(1'b0, 4'd3, k);
    check("aborted_cleared", {31'd0, aborted}, 32'd0);
    push(0, k, 1'b0);
    push(1, k + P_S, 1'b0);
    wait_cyc(k + P_S + 50);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    d = k + P_S + G;
    push(2, d, 1'b1);
    wait_cyc(d - 1);
    issue(1'b0, 4'd1, a);
    check("return_edge_busy", {31'd0, busy}, 32'd0);
    wait_cyc(d + 20);
    check("return_edge_btn", {31'd0, btn}, 32'd0);
    check("return_edge_aborted", {31'd0, aborted}, 32'd1);

    // START in the DONE cycle is accepted on the next edge
    issue(1'b0, 4'd1, k);
    push_seq(k, 1'b0, 1);
    d = k + P_S + G;
    wait_cyc(d);
    issue(1'b0, 4'd1, k2);
    push_seq(d + 1, 1'b0, 1);
    wait_cyc(d + 1 + P_S + G);
    @(negedge clk);

    // Asynchronous reset mid-press
    issue(1'b0, 4'd1, k);
    push(0, k, 1'b0);
    wait_cyc(k + 50);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    c = cyc;
    push(1, c, 1'b0);
    #1;
    check("async_reset_btn", {31'd0, btn}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 4'd1, k);
    push_seq(k, 1'b1, 1);
    wait_cyc(k + 1400);
    check("post_reset_done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
